// File: rtl/ysyx_22041071_div_issue.sv
// ysyx_22041071_div_issue
// Requester-side issue/collect controller for the iterative RV64M divider.
// It latches one div/rem op from the EXU and holds the divider inputs stable
// until out_valid. Divide-by-zero and signed overflow are resolved here, and
// word results are sign-extended. A flush drops the op without re-triggering
// the divider.
// Optional macro YSYX_22041071_DIV_FASTPATH_EN: when it is defined, the
// zero/overflow cases complete one cycle after accept and bypass the divider.
// When it is not defined, those cases still go through the divider, and the
// fixed result replaces the divider output at capture.
`timescale 1ns/1ps

module ysyx_22041071_div_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic        op_ready,
  output logic        res_valid,
  output logic [63:0] result,
  output logic        div_valid,
  output logic        div_signed,
  output logic        divw,
  output logic        div_flush,
  output logic [63:0] dividend,
  output logic [63:0] divisor,
  input  logic        div_ready,
  input  logic        out_valid,
  input  logic [63:0] quot,
  input  logic [63:0] rema
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [1:0]  op_q;        // {word, remainder}; signedness lives in div_signed
  logic [63:0] raw_res;
  logic [63:0] norm_res;

  // Returns {hit, value}. A hit is divide-by-zero or signed overflow,
  // and value is the architectural result for that case.
  function automatic logic [64:0] special_case(input logic [2:0]  o,
                                               input logic [63:0] a,
                                               input logic [63:0] b);
    logic word;
    logic zero;
    logic ovf;
    logic [63:0] a_ext;
    word  = o[2];
    a_ext = word ? {{32{a[31]}}, a[31:0]} : a;
    zero  = word ? (b[31:0] == 32'h0) : (b == 64'h0);
    ovf   = !o[0] && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (zero)
      special_case = {1'b1, o[1] ? a_ext : 64'hFFFF_FFFF_FFFF_FFFF};
    else if (ovf)
      special_case = {1'b1, o[1] ? 64'h0 : (word ? 64'hFFFF_FFFF_8000_0000
                                                 : 64'h8000_0000_0000_0000)};
    else
      special_case = 65'h0;
  endfunction

  // A new op is taken only when the divider is idle and nothing is being cancelled
  assign op_ready  = (state == IDLE) && div_ready && !flush;
  assign div_flush = flush;

  // Select the divider output and sign-extend it for word ops
  assign raw_res  = op_q[0] ? rema : quot;
  assign norm_res = op_q[1] ? {{32{raw_res[31]}}, raw_res[31:0]} : raw_res;

`ifdef YSYX_22041071_DIV_FASTPATH_EN
  logic [64:0] acc_special;
  assign acc_special = special_case(op, src1, src2);
`else
  logic [64:0] done_special;
  assign done_special = special_case({op_q[1], op_q[0], ~div_signed}, dividend, divisor);
`endif

  // Issue/collect FSM; every divider-facing output is registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= 2'b00;
      res_valid  <= 1'b0;
      result     <= 64'h0;
      div_valid  <= 1'b0;
      div_signed <= 1'b0;
      divw       <= 1'b0;
      dividend   <= 64'h0;
      divisor    <= 64'h0;
    end else if (flush) begin
      // The divider finishes on its own; its late out_valid is ignored in IDLE
      state      <= IDLE;
      res_valid  <= 1'b0;
      div_valid  <= 1'b0;
      div_signed <= 1'b0;
      divw       <= 1'b0;
      dividend   <= 64'h0;
      divisor    <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          if (op_valid && op_ready) begin
            op_q <= {op[2], op[1]};
`ifdef YSYX_22041071_DIV_FASTPATH_EN
            if (acc_special[64]) begin
              result    <= acc_special[63:0];
              res_valid <= 1'b1;
              state     <= RESP;
            end else begin
              div_valid  <= 1'b1;
              div_signed <= !op[0];
              divw       <= op[2];
              dividend   <= src1;
              divisor    <= src2;
              state      <= WAIT;
            end
`else
            div_valid  <= 1'b1;
            div_signed <= !op[0];
            divw       <= op[2];
            dividend   <= src1;
            divisor    <= src2;
            state      <= WAIT;
`endif
          end
        end
        WAIT: begin
          if (out_valid) begin
            // Drop div_valid now so the divider does not restart after DONE
            div_valid  <= 1'b0;
            div_signed <= 1'b0;
            divw       <= 1'b0;
            dividend   <= 64'h0;
            divisor    <= 64'h0;
            res_valid  <= 1'b1;
            state      <= RESP;
`ifdef YSYX_22041071_DIV_FASTPATH_EN
            result <= norm_res;
`else
            result <= done_special[64] ? done_special[63:0] : norm_res;
`endif
          end
        end
        RESP: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_div_issue.sv
// Directed testbench for ysyx_22041071_div_issue, with a behavioural
// iterative divider. The divider has a fixed latency. It puts junk in the
// upper word of word results and junk in the special cases, so the DUT must
// sign-extend and substitute those results itself.
`timescale 1ns/1ps

module tb_ysyx_22041071_div_issue;

  localparam int LAT = 30;

  logic        clk = 1'b0;
  logic        reset, flush, op_valid;
  logic [2:0]  op;
  logic [63:0] src1, src2;
  logic        op_ready, res_valid;
  logic [63:0] result;
  logic        div_valid, div_signed, divw, div_flush;
  logic [63:0] dividend, divisor;
  logic        div_ready, out_valid;
  logic [63:0] quot, rema;

  int checks = 0;
  int errors = 0;

  ysyx_22041071_div_issue dut (
    .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op(op),
    .src1(src1), .src2(src2), .op_ready(op_ready), .res_valid(res_valid),
    .result(result), .div_valid(div_valid), .div_signed(div_signed),
    .divw(divw), .div_flush(div_flush), .dividend(dividend), .divisor(divisor),
    .div_ready(div_ready), .out_valid(out_valid), .quot(quot), .rema(rema)
  );

  always #5 clk = ~clk;

  // Returns {quot, rema}. The special cases return junk on purpose.
  function automatic logic [127:0] model_div(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input logic w);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'h0 || (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF))
        return {64'h0BAD_C0DE_0BAD_C0DE, 64'h0BAD_C0DE_0BAD_C0DE};
      if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      return {32'hDEAD_BEEF, q32, 32'h5A5A_5A5A, r32};
    end
    if (b == 64'h0 || (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF))
      return {64'h0BAD_C0DE_0BAD_C0DE, 64'h0BAD_C0DE_0BAD_C0DE};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Behavioural divider: busy for LAT cycles, one DONE cycle with out_valid,
  // then ready again. It ignores div_flush and runs to completion.
  logic        busy;
  int          cnt;
  logic [63:0] a_l, b_l;
  logic        s_l, w_l;
  always @(posedge clk) begin
    if (reset) begin
      div_ready <= 1'b1; out_valid <= 1'b0; busy <= 1'b0; cnt <= 0;
      quot <= 64'h0; rema <= 64'h0;
    end else begin
      out_valid <= 1'b0;
      if (!busy) begin
        if (div_valid && div_ready) begin
          busy <= 1'b1; div_ready <= 1'b0; cnt <= LAT;
          a_l <= dividend; b_l <= divisor; s_l <= div_signed; w_l <= divw;
        end
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end else if (cnt == 1) begin
        cnt <= 0;
        out_valid <= 1'b1;
        {quot, rema} <= model_div(a_l, b_l, s_l, w_l);
      end else begin
        busy <= 1'b0;
        div_ready <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait for its result. A special case with the fast path
  // built in must land one cycle after accept. All other ops land the cycle
  // after out_valid.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input logic fast);
    int n;
    logic prev_ov;
    logic got;
    n = 0;
    while (!op_ready && n < 300) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, {63'h0, op_ready}, 64'h1);
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    op_valid = 1'b0;
    prev_ov = 1'b0; got = 1'b0; n = 1;
    while (n < 300) begin
      if (res_valid) begin got = 1'b1; break; end
      prev_ov = out_valid;
      @(negedge clk);
      n++;
    end
    chk({tag, "_got"}, {63'h0, got}, 64'h1);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_dvlow"}, {63'h0, div_valid}, 64'h0);
`ifdef YSYX_22041071_DIV_FASTPATH_EN
    if (fast) chk({tag, "_lat"}, 64'(n), 64'd1);
    else      chk({tag, "_afterov"}, {63'h0, prev_ov}, 64'h1);
`else
    chk({tag, "_afterov"}, {63'h0, prev_ov}, 64'h1);
`endif
    @(negedge clk);
    chk({tag, "_once"}, {63'h0, res_valid}, 64'h0);
    chk({tag, "_hold"}, result, exp);
    $display("op %s op=%b src1=%h src2=%h result=%h latency=%0d", tag, o, a, b, result, n);
  endtask

  initial begin
    int n;
    int bad;
    logic stale;
    reset = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'b000; src1 = 64'h0; src2 = 64'h0;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", {63'h0, res_valid}, 64'h0);
    chk("rst_div_valid", {63'h0, div_valid}, 64'h0);
    chk("rst_result", result, 64'h0);
    chk("rst_dividend", dividend, 64'h0);
    chk("rst_op_ready", {63'h0, op_ready}, 64'h1);
    reset = 1'b0;
    @(negedge clk);

    run_op("div_m7_2",   3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("remw_m7_2",  3'b110, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("divuw_m7_2", 3'b101, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 1'b0);
    run_op("divu_5_0",   3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("remu_5_0",   3'b011, 64'd5, 64'd0, 64'd5, 1'b1);
    run_op("remw_z",     3'b110, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000,
           64'hFFFF_FFFF_8000_0005, 1'b1);
    run_op("div_ovf",    3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b1);
    run_op("rem_ovf",    3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    run_op("divw_ovf",   3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1'b1);

    // Flush 20 cycles into WAIT
    op_valid = 1'b1; op = 3'b000; src1 = 64'd1000; src2 = 64'd3;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("fl_in_wait", {63'h0, div_valid}, 64'h1);
    flush = 1'b1;
    #1;
    chk("fl_div_flush", {63'h0, div_flush}, 64'h1);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_res_valid", {63'h0, res_valid}, 64'h0);
    chk("fl_div_valid", {63'h0, div_valid}, 64'h0);
    chk("fl_op_ready", {63'h0, op_ready}, 64'h0);
    bad = 0; stale = 1'b0; n = 0;
    while (!div_ready && n < 300) begin
      if (res_valid || op_ready) bad++;
      if (out_valid) stale = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("fl_stale_seen", {63'h0, stale}, 64'h1);
    chk("fl_no_res", 64'(bad), 64'd0);
    chk("fl_res_after", {63'h0, res_valid}, 64'h0);
    run_op("divu_100_7", 3'b001, 64'd100, 64'd7, 64'd14, 1'b0);

    // Flush in the same cycle as out_valid: flush wins
    op_valid = 1'b1; op = 3'b000; src1 = 64'd50; src2 = 64'd5;
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    chk("flov_seen", {63'h0, out_valid}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flov_res0", {63'h0, res_valid}, 64'h0);
    @(negedge clk);
    chk("flov_res1", {63'h0, res_valid}, 64'h0);
    chk("flov_result", result, 64'd14);

    // Reset in the middle of WAIT
    op_valid = 1'b1; op = 3'b001; src1 = 64'd9; src2 = 64'd2;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_res_valid", {63'h0, res_valid}, 64'h0);
    chk("mr_div_valid", {63'h0, div_valid}, 64'h0);
    chk("mr_result", result, 64'h0);
    chk("mr_divisor", divisor, 64'h0);
    chk("mr_op_ready", {63'h0, op_ready}, 64'h1);
    reset = 1'b0;
    @(negedge clk);
    run_op("rem_17_m5", 3'b010, 64'd17, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
